board_search: RTL and testbench

Search engine that sits on the read/write ports of the puzzle board register file. On `start` it reads the question board from the question slot and scans the solved-board table two entries per cycle, using both read ports. It writes the result word into the answer slot through the write port, then pulses `done`. It is the initiator on the register-file interface: it drives addresses and write data, and consumes read data.

---
 rtl/puzzle_pkg.sv | 32 +++
 rtl/pair_match.sv | 37 +++
 rtl/board_search.sv | 159 +++++++++++++++
 tb/tb_board_search.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// puzzle_pkg
// Shared definitions for the puzzle board register file and the search
// engine that sits on its ports.
//   W, AW                 : board word width and register address width
//   N_BOARDS              : solved-board table entries, addresses 0..N_BOARDS-1
//   Q_ADDR, A_ADDR        : question slot and answer slot addresses
//   board_t               : one board word
//   state_t               : search engine FSM states
//   ANS_VALID_BIT/IDX_MSB : field layout of the answer word
package puzzle_pkg;

  localparam int W        = 45;
  localparam int AW       = 6;
  localparam int N_BOARDS = 60;
  localparam int Q_ADDR   = 60;
  localparam int A_ADDR   = 61;

  typedef logic [W-1:0] board_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_WRITE,
    S_DONE
  } state_t;

  // Answer word: {zeros, valid, index}
  localparam int ANS_VALID_BIT = AW;
  localparam int ANS_IDX_MSB   = AW - 1;

endpackage

// File: rtl/pair_match.sv
// pair_match
// Combinational two-way board compare. Port A holds the even table entry and
// port B the odd one, so giving port A priority makes the lowest index win.
//   question : board being searched for
//   outa     : table entry at index base
//   outb     : table entry at index base+1
//   base     : even table index of this pair
//   hit      : either entry matches the question on all W bits
//   hit_idx  : index of the matching entry (valid when hit)
module pair_match #(
  parameter int W  = 45,
  parameter int AW = 6
) (
  input  logic [W-1:0]  question,
  input  logic [W-1:0]  outa,
  input  logic [W-1:0]  outb,
  input  logic [AW-1:0] base,
  output logic          hit,
  output logic [AW-1:0] hit_idx
);

  logic match_a;
  logic match_b;

  assign match_a = (outa == question);
  assign match_b = (outb == question);

  // base is always even, so base+1 only sets bit 0
  always_comb begin
    hit     = match_a | match_b;
    hit_idx = base;
    if (!match_a && match_b) begin
      hit_idx = {base[AW-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/board_search.sv
// board_search
// Search engine on the read/write ports of the puzzle board register file.
// On start it loads the question board, scans the solved-board table two
// entries per cycle, writes the result word into the answer slot and pulses
// done. Read data is consumed combinationally in the cycle its address is
// driven.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a search (only accepted in IDLE)
//   src0, src1 : read addresses for ports A and B
//   outa, outb : read data for ports A and B
//   dst, we    : write address and enable
//   data       : write data ({zeros, found, index} or 0 on no match)
//   busy       : engine is not idle
//   done       : one-cycle completion pulse
//   found      : last search matched
//   index      : matched table index (valid when found)
module board_search #(
  parameter int W        = puzzle_pkg::W,
  parameter int AW       = puzzle_pkg::AW,
  parameter int N_BOARDS = puzzle_pkg::N_BOARDS,
  parameter int Q_ADDR   = puzzle_pkg::Q_ADDR,
  parameter int A_ADDR   = puzzle_pkg::A_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] src0,
  output logic [AW-1:0] src1,
  input  logic [W-1:0]  outa,
  input  logic [W-1:0]  outb,
  output logic [AW-1:0] dst,
  output logic          we,
  output logic [W-1:0]  data,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] index
);

  import puzzle_pkg::*;

  localparam logic [AW-1:0] Q_SLOT = AW'(Q_ADDR);
  localparam logic [AW-1:0] A_SLOT = AW'(A_ADDR);
  // Pair counter only needs to reach N_BOARDS/2-1; the address is {k, odd}
  localparam logic [AW-2:0] K_LAST = (AW-1)'(N_BOARDS / 2 - 1);

  state_t          state;
  state_t          state_next;
  logic [AW-2:0]   k;
  logic [W-1:0]    question;
  logic [AW-1:0]   pair_base;
  logic            hit;
  logic [AW-1:0]   hit_idx;

  assign pair_base = {k, 1'b0};

  pair_match #(
    .W  (W),
    .AW (AW)
  ) u_pair_match (
    .question (question),
    .outa     (outa),
    .outb     (outb),
    .base     (pair_base),
    .hit      (hit),
    .hit_idx  (hit_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pair counter, question register and result flags. found/index are only
  // touched when a start is accepted or a match is seen, so they hold until
  // the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      question <= '0;
      found    <= 1'b0;
      index    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k     <= '0;
            found <= 1'b0;
            index <= '0;
          end
        end
        S_LOAD: begin
          question <= outa;
        end
        S_SCAN: begin
          if (hit) begin
            found <= 1'b1;
            index <= hit_idx;
          end else if (k != K_LAST) begin
            k <= k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and all port drive. Every output defaults to 0 so that reset
  // (which forces IDLE) leaves the register-file ports quiet immediately.
  always_comb begin
    state_next = state;
    src0       = '0;
    src1       = '0;
    dst        = '0;
    we         = 1'b0;
    data       = '0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        src0       = Q_SLOT;
        state_next = S_SCAN;
      end
      S_SCAN: begin
        src0 = {k, 1'b0};
        src1 = {k, 1'b1};
        if (hit || (k == K_LAST)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        we  = 1'b1;
        dst = A_SLOT;
        if (found) begin
          data[ANS_VALID_BIT]   = 1'b1;
          data[ANS_IDX_MSB:0]   = index;
        end
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_board_search.sv
// tb_board_search
// Directed bench for board_search. Models the puzzle board register file
// (two combinational read ports, one write port shared between the engine
// and host-side preloads) and checks write timing, answer words, flags,
// priority, ignored starts and mid-search reset.
module tb_board_search;

  import puzzle_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src0;
  logic [AW-1:0] src1;
  logic [W-1:0]  outa;
  logic [W-1:0]  outb;
  logic [AW-1:0] dst;
  logic          we;
  logic [W-1:0]  data;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] index;

  logic          initRf;
  logic          hostWe;
  logic [AW-1:0] hostAddr;
  logic [W-1:0]  hostData;
  logic [W-1:0]  rf [0:63];

  int total = 0;
  int bad   = 0;
  logic [W-1:0] lastAnswer;

  always #5 clk = ~clk;

  board_search dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src0  (src0),
    .src1  (src1),
    .outa  (outa),
    .outb  (outb),
    .dst   (dst),
    .we    (we),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .found (found),
    .index (index)
  );

  // Distinct table boards; the top 13 bits are never zero, so 45'h1 misses
  function automatic logic [W-1:0] entry(input int i);
    logic [12:0] hi;
    logic [31:0] lo;
    hi = 13'(i * 37 + 5);
    lo = 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101);
    return {hi, lo};
  endfunction

  assign outa = rf[src0];
  assign outb = rf[src1];

  // Register file: table preload, engine writes, then host writes
  always @(posedge clk) begin
    if (initRf) begin
      for (int i = 0; i < 64; i++) begin
        rf[i] <= (i < N_BOARDS) ? entry(i) : '0;
      end
      rf[Q_ADDR] <= entry(1);
    end else if (we) begin
      rf[dst] <= data;
    end else if (hostWe) begin
      rf[hostAddr] <= hostData;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hostWrite(input logic [AW-1:0] addr, input logic [W-1:0] value);
    @(negedge clk);
    hostWe   = 1'b1;
    hostAddr = addr;
    hostData = value;
    @(negedge clk);
    hostWe   = 1'b0;
  endtask

  // One accepted start, then observe until done (bounded). start is
  // re-pulsed during cycles pulseA/pulseB, which must be ignored.
  task automatic applyStimulus(input string tag, input int expWeCycle, input logic [W-1:0] expData,
                               input logic expFound, input logic [AW-1:0] expIndex,
                               input int pulseA, input int pulseB);
    int weCount;
    int weCycle;
    int doneCycle;
    int c;
    logic [AW-1:0] wDst;
    logic [W-1:0]  wData;
    logic [W-1:0]  slotAtDone;
    weCount    = 0;
    weCycle    = -1;
    doneCycle  = -1;
    wDst       = '0;
    wData      = '0;
    slotAtDone = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".busy_load"}, 64'(busy), 64'd1);
    checkOutput({tag, ".found_cleared"}, 64'(found), 64'd0);
    checkOutput({tag, ".src0_load"}, 64'(src0), 64'(Q_ADDR));
    c = 1;
    while (doneCycle < 0 && c <= 60) begin
      start = (c == pulseA) || (c == pulseB);
      if (we) begin
        weCount++;
        if (weCycle < 0) begin
          weCycle = c;
          wDst    = dst;
          wData   = data;
        end
      end
      if (done) begin
        doneCycle  = c;
        slotAtDone = rf[A_ADDR];
      end else begin
        @(negedge clk);
        c++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (we) weCount++;
    end
    checkOutput({tag, ".we_cycle"}, 64'(weCycle), 64'(expWeCycle));
    checkOutput({tag, ".dst"}, 64'(wDst), 64'(A_ADDR));
    checkOutput({tag, ".data"}, 64'(wData), 64'(expData));
    checkOutput({tag, ".done_cycle"}, 64'(doneCycle), 64'(expWeCycle + 1));
    checkOutput({tag, ".slot_at_done"}, 64'(slotAtDone), 64'(expData));
    checkOutput({tag, ".we_count"}, 64'(weCount), 64'd1);
    checkOutput({tag, ".found"}, 64'(found), 64'(expFound));
    checkOutput({tag, ".index"}, 64'(index), 64'(expIndex));
    checkOutput({tag, ".busy_after"}, 64'(busy), 64'd0);
    lastAnswer = expData;
  endtask

  initial begin
    int weCount;
    rst      = 1'b1;
    start    = 1'b0;
    initRf   = 1'b1;
    hostWe   = 1'b0;
    hostAddr = '0;
    hostData = '0;
    lastAnswer = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst.src0", 64'(src0), 64'd0);
    checkOutput("rst.src1", 64'(src1), 64'd0);
    checkOutput("rst.dst", 64'(dst), 64'd0);
    checkOutput("rst.we", 64'(we), 64'd0);
    checkOutput("rst.data", 64'(data), 64'd0);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.found", 64'(found), 64'd0);
    checkOutput("rst.index", 64'(index), 64'd0);
    initRf = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    $display("[TB] default question matches entry 1");
    applyStimulus("q1", 3, 45'h41, 1'b1, 6'd1, 0, 0);

    $display("[TB] last entry, start pulsed in SCAN and DONE");
    hostWrite(6'(Q_ADDR), entry(59));
    applyStimulus("q59", 32, 45'h7B, 1'b1, 6'd59, 15, 33);

    $display("[TB] question not in table");
    hostWrite(6'(Q_ADDR), 45'h1);
    applyStimulus("miss", 32, 45'h0, 1'b0, 6'd0, 0, 0);

    $display("[TB] duplicate in lower slot wins");
    hostWrite(6'd4, entry(10));
    hostWrite(6'(Q_ADDR), entry(10));
    applyStimulus("prio4", 5, 45'h44, 1'b1, 6'd4, 0, 0);

    $display("[TB] port A wins within a pair");
    hostWrite(6'd4, entry(4));
    hostWrite(6'd11, entry(10));
    applyStimulus("prioA", 8, 45'h4A, 1'b1, 6'd10, 0, 0);

    $display("[TB] reset in the middle of a search");
    hostWrite(6'(Q_ADDR), entry(59));
    weCount = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (we) weCount++;
      @(negedge clk);
    end
    checkOutput("abort.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort.src0", 64'(src0), 64'd0);
    checkOutput("abort.src1", 64'(src1), 64'd0);
    checkOutput("abort.dst", 64'(dst), 64'd0);
    checkOutput("abort.we", 64'(we), 64'd0);
    checkOutput("abort.data", 64'(data), 64'd0);
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.done", 64'(done), 64'd0);
    checkOutput("abort.found", 64'(found), 64'd0);
    checkOutput("abort.index", 64'(index), 64'd0);
    repeat (2) begin
      @(negedge clk);
      if (we) weCount++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (we) weCount++;
    end
    checkOutput("abort.we_count", 64'(weCount), 64'd0);
    checkOutput("abort.slot61", 64'(rf[A_ADDR]), 64'(lastAnswer));
    checkOutput("abort.idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
